// File: rtl/freq_divider_tracker.sv
// Measures the InFreq period in RefClk cycles and synthesises OutFreq with
// period = measured period * 2^n. Exposes the adjust/done lock handshake.
module freq_divider_tracker #(
    parameter int WIDTH = 16
) (
    input  logic             RefClk,
    input  logic             rst,
    input  logic             adjust,
    input  logic             InFreq,
    input  logic [2:0]       n,
    output logic             OutFreq,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] period,
    output logic [15:0]      shiftduration
);

    localparam int TW = WIDTH + 7;
    // Timeout fires on the cycle the counter would reach its all-ones value.
    localparam logic [WIDTH-1:0] CNT_TRIP = {{(WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT1,
        S_MEASURE,
        S_SCALE,
        S_RUN
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             sync3_q, sync3_d;
    logic             in_edge_q, in_edge_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    tgt_q, tgt_d;
    logic [TW-1:0]    ocnt_q, ocnt_d;
    logic [2:0]       shc_q, shc_d;
    logic [2:0]       n_r_q, n_r_d;
    logic [15:0]      timer_q, timer_d;
    logic             out_q, out_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [15:0]      shdur_q, shdur_d;
    logic [15:0]      timer_inc;
    logic             enter_run;

    always_comb begin
        state_d   = state_q;
        sync1_d   = InFreq;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        in_edge_d = sync2_q & ~sync3_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        ocnt_d    = ocnt_q;
        shc_d     = shc_q;
        n_r_d     = n_r_q;
        timer_d   = timer_q;
        out_d     = out_q;
        done_d    = done_q;
        err_d     = err_q;
        period_d  = period_q;
        shdur_d   = shdur_q;
        enter_run = 1'b0;
        timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

        case (state_q)
            S_WAIT1: begin
                timer_d = timer_inc;
                if (in_edge_q) begin
                    cnt_d   = {{(WIDTH-1){1'b0}}, 1'b1};
                    state_d = S_MEASURE;
                end else if (cnt_q == CNT_TRIP) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_MEASURE: begin
                timer_d = timer_inc;
                if (in_edge_q) begin
                    period_d = cnt_q;
                    tgt_d    = TW'(cnt_q);
                    shc_d    = n_r_q;
                    if (n_r_q == 3'd0) enter_run = 1'b1;
                    else               state_d   = S_SCALE;
                end else if (cnt_q == CNT_TRIP) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SCALE: begin
                timer_d = timer_inc;
                tgt_d   = tgt_q << 1;
                shc_d   = shc_q - 3'd1;
                if (shc_q == 3'd1) enter_run = 1'b1;
            end
            S_RUN: begin
                ocnt_d = (ocnt_q == tgt_q - 1'b1) ? '0 : ocnt_q + 1'b1;
                // Odd targets put the extra cycle in the low phase.
                out_d  = (ocnt_d < (tgt_q >> 1));
            end
            default: ;
        endcase

        if (enter_run) begin
            state_d = S_RUN;
            done_d  = 1'b1;
            ocnt_d  = '0;
            out_d   = 1'b1;
            shdur_d = timer_inc;
        end

        if (adjust && (state_q == S_IDLE || state_q == S_RUN)) begin
            n_r_d   = n;
            err_d   = 1'b0;
            done_d  = 1'b0;
            out_d   = 1'b0;
            timer_d = '0;
            cnt_d   = '0;
            state_d = S_WAIT1;
        end
    end

    always_ff @(posedge RefClk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
            in_edge_q <= 1'b0;
            cnt_q     <= '0;
            tgt_q     <= '0;
            ocnt_q    <= '0;
            shc_q     <= '0;
            n_r_q     <= '0;
            timer_q   <= '0;
            out_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            period_q  <= '0;
            shdur_q   <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
            in_edge_q <= in_edge_d;
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            ocnt_q    <= ocnt_d;
            shc_q     <= shc_d;
            n_r_q     <= n_r_d;
            timer_q   <= timer_d;
            out_q     <= out_d;
            done_q    <= done_d;
            err_q     <= err_d;
            period_q  <= period_d;
            shdur_q   <= shdur_d;
        end
    end

    assign OutFreq       = out_q;
    assign done          = done_q;
    assign err           = err_q;
    assign period        = period_q;
    assign shiftduration = shdur_q;

endmodule

// File: tb/tb_freq_divider_tracker.sv
// Directed bench for freq_divider_tracker: lock latency, measured period,
// divided output shape, relock, timeout error and reset abort.
module tb_freq_divider_tracker;

    logic        RefClk;
    logic        rst;
    logic        adjust;
    logic        adjust8;
    logic        InFreq;
    logic [2:0]  n;
    logic        OutFreq, done, err;
    logic [15:0] period, shiftduration;
    logic        OutFreq8, done8, err8;
    logic [7:0]  period8;
    logic [15:0] shiftduration8;

    int n_chk  = 0;
    int n_fail = 0;
    int gen_p  = 0;
    int gen_hi = 0;
    int ph     = 0;

    freq_divider_tracker #(.WIDTH(16)) dut (
        .RefClk(RefClk), .rst(rst), .adjust(adjust), .InFreq(InFreq), .n(n),
        .OutFreq(OutFreq), .done(done), .err(err), .period(period),
        .shiftduration(shiftduration)
    );

    freq_divider_tracker #(.WIDTH(8)) dut8 (
        .RefClk(RefClk), .rst(rst), .adjust(adjust8), .InFreq(InFreq), .n(n),
        .OutFreq(OutFreq8), .done(done8), .err(err8), .period(period8),
        .shiftduration(shiftduration8)
    );

    initial RefClk = 1'b0;
    always #5 RefClk = ~RefClk;

    // RefClk-aligned InFreq: changes 1ns after each rising edge.
    initial begin
        InFreq = 1'b0;
        forever begin
            @(posedge RefClk);
            #1;
            if (gen_p > 0) begin
                if (ph >= gen_p - 1) ph = 0;
                else                 ph = ph + 1;
                InFreq = (ph < gen_hi);
            end else begin
                InFreq = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge RefClk);
        #1;
    endtask

    // Returns at a falling edge just after an InFreq rise.
    task automatic sync_rise();
        logic prev;
        bit   found;
        found = 0;
        @(negedge RefClk);
        prev = InFreq;
        for (int i = 0; i < 300; i++) begin
            @(negedge RefClk);
            if (InFreq && !prev) begin
                found = 1;
                break;
            end
            prev = InFreq;
        end
        n_chk++;
        if (!found) begin
            n_fail++;
            $display("FAIL sync_rise: no InFreq rise seen within 300 cycles (got none, need one)");
        end
    endtask

    task automatic wait_done(inout int cyc);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            cyc++;
            if (done) begin
                ok = 1;
                break;
            end
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL lock_timeout: done=%0b after %0d cycles, need 1", done, cyc);
        end
    endtask

    task automatic start_lock(input logic [2:0] nv, output int cyc);
        n = nv;
        sync_rise();
        adjust = 1'b1;
        tick();
        adjust = 1'b0;
        cyc = 0;
        wait_done(cyc);
    endtask

    // Captures one full high phase and the following low phase of OutFreq.
    task automatic get_hl(output int hi, output int lo);
        int  k;
        bit  ok;
        hi = 0;
        lo = 0;
        ok = 1;
        k  = 0;
        while (OutFreq !== 1'b0 && k < 1000) begin tick(); k++; end
        while (OutFreq !== 1'b1 && k < 1000) begin tick(); k++; end
        while (OutFreq === 1'b1 && k < 1000) begin hi++; tick(); k++; end
        while (OutFreq === 1'b0 && k < 1000) begin lo++; tick(); k++; end
        if (k >= 1000) ok = 0;
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL outfreq_timeout: waveform not settled within %0d cycles (hi=%0d lo=%0d)", k, hi, lo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; adjust = 1'b0; adjust8 = 1'b0; n = 3'd0; gen_p = 0;
        repeat (3) tick();
        n_chk++; if (OutFreq !== 1'b0) begin n_fail++; $display("FAIL reset_outfreq: got %0b need 0", OutFreq); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b need 0", done); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b need 0", err); end
        n_chk++; if (period !== 16'd0) begin n_fail++; $display("FAIL reset_period: got %0d need 0", period); end
        n_chk++; if (shiftduration !== 16'd0) begin n_fail++; $display("FAIL reset_shdur: got %0d need 0", shiftduration); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_n2_p10();
        int cyc, hi, lo;
        gen_p = 10; gen_hi = 5;
        repeat (20) tick();
        start_lock(3'd2, cyc);
        n_chk++; if (cyc != 15) begin n_fail++; $display("FAIL n2_lock_cycles: got %0d need 15", cyc); end
        n_chk++; if (shiftduration !== 16'd15) begin n_fail++; $display("FAIL n2_shdur: got %0d need 15", shiftduration); end
        n_chk++; if (period !== 16'd10) begin n_fail++; $display("FAIL n2_period: got %0d need 10", period); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL n2_err: got %0b need 0", err); end
        get_hl(hi, lo);
        n_chk++; if (hi != 20) begin n_fail++; $display("FAIL n2_high: got %0d need 20", hi); end
        n_chk++; if (lo != 20) begin n_fail++; $display("FAIL n2_low: got %0d need 20", lo); end
    endtask

    task automatic test_back_to_back();
        int cyc, hi, lo;
        n = 3'd3;
        sync_rise();
        adjust = 1'b1;
        tick();
        adjust = 1'b0;
        cyc = 0;
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %0b need 0", done); end
        n_chk++; if (OutFreq !== 1'b0) begin n_fail++; $display("FAIL b2b_out_drop: got %0b need 0", OutFreq); end
        repeat (4) begin tick(); cyc++; end
        n = 3'd5;
        adjust = 1'b1;
        tick(); cyc++;
        adjust = 1'b0;
        n = 3'd3;
        wait_done(cyc);
        n_chk++; if (cyc != 16) begin n_fail++; $display("FAIL b2b_lock_cycles: got %0d need 16", cyc); end
        n_chk++; if (shiftduration !== 16'd16) begin n_fail++; $display("FAIL b2b_shdur: got %0d need 16", shiftduration); end
        n_chk++; if (period !== 16'd10) begin n_fail++; $display("FAIL b2b_period: got %0d need 10", period); end
        get_hl(hi, lo);
        n_chk++; if (hi != 40) begin n_fail++; $display("FAIL b2b_high: got %0d need 40", hi); end
        n_chk++; if (lo != 40) begin n_fail++; $display("FAIL b2b_low: got %0d need 40", lo); end
    endtask

    task automatic test_n0_p10();
        int cyc, hi, lo;
        start_lock(3'd0, cyc);
        n_chk++; if (cyc != 13) begin n_fail++; $display("FAIL n0_lock_cycles: got %0d need 13", cyc); end
        n_chk++; if (shiftduration !== 16'd13) begin n_fail++; $display("FAIL n0_shdur: got %0d need 13", shiftduration); end
        get_hl(hi, lo);
        n_chk++; if (hi != 5) begin n_fail++; $display("FAIL n0_high: got %0d need 5", hi); end
        n_chk++; if (lo != 5) begin n_fail++; $display("FAIL n0_low: got %0d need 5", lo); end
    endtask

    task automatic test_p7();
        int cyc, hi, lo;
        gen_p = 7; gen_hi = 3;
        repeat (20) tick();
        start_lock(3'd1, cyc);
        n_chk++; if (cyc != 11) begin n_fail++; $display("FAIL p7n1_lock_cycles: got %0d need 11", cyc); end
        n_chk++; if (period !== 16'd7) begin n_fail++; $display("FAIL p7n1_period: got %0d need 7", period); end
        get_hl(hi, lo);
        n_chk++; if (hi != 7) begin n_fail++; $display("FAIL p7n1_high: got %0d need 7", hi); end
        n_chk++; if (lo != 7) begin n_fail++; $display("FAIL p7n1_low: got %0d need 7", lo); end
        start_lock(3'd0, cyc);
        n_chk++; if (cyc != 10) begin n_fail++; $display("FAIL p7n0_lock_cycles: got %0d need 10", cyc); end
        get_hl(hi, lo);
        n_chk++; if (hi != 3) begin n_fail++; $display("FAIL p7n0_high: got %0d need 3", hi); end
        n_chk++; if (lo != 4) begin n_fail++; $display("FAIL p7n0_low: got %0d need 4", lo); end
    endtask

    task automatic test_overflow();
        int  cyc;
        bit  seen;
        gen_p = 0;
        repeat (10) tick();
        @(negedge RefClk);
        adjust8 = 1'b1;
        tick();
        adjust8 = 1'b0;
        cyc  = 0;
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            cyc++;
            if (err8) begin
                seen = 1;
                break;
            end
        end
        n_chk++; if (!seen || cyc != 255) begin n_fail++; $display("FAIL ovf_err_cycles: got %0d (seen=%0b) need 255", cyc, seen); end
        n_chk++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL ovf_done: got %0b need 0", done8); end
        n_chk++; if (period8 !== 8'd0) begin n_fail++; $display("FAIL ovf_period: got %0d need 0", period8); end
        repeat (5) tick();
        n_chk++; if (err8 !== 1'b1) begin n_fail++; $display("FAIL ovf_err_sticky: got %0b need 1", err8); end
        gen_p = 10; gen_hi = 5;
        @(negedge RefClk);
        adjust8 = 1'b1;
        tick();
        adjust8 = 1'b0;
        n_chk++; if (err8 !== 1'b0) begin n_fail++; $display("FAIL ovf_err_clear: got %0b need 0", err8); end
    endtask

    task automatic test_reset_mid();
        int bad;
        gen_p = 10; gen_hi = 5;
        n = 3'd1;
        sync_rise();
        adjust = 1'b1;
        tick();
        adjust = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %0b need 0", done); end
        n_chk++; if (OutFreq !== 1'b0) begin n_fail++; $display("FAIL rstmid_out: got %0b need 0", OutFreq); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %0b need 0", err); end
        n_chk++; if (period !== 16'd0) begin n_fail++; $display("FAIL rstmid_period: got %0d need 0", period); end
        n_chk++; if (shiftduration !== 16'd0) begin n_fail++; $display("FAIL rstmid_shdur: got %0d need 0", shiftduration); end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (done !== 1'b0 || OutFreq !== 1'b0 || period !== 16'd0) bad++;
        end
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_idle: %0d active cycles, need 0", bad); end
    endtask

    initial begin
        rst = 1'b1; adjust = 1'b0; adjust8 = 1'b0; n = 3'd0;
        test_reset();
        test_n2_p10();
        test_back_to_back();
        test_n0_p10();
        test_p7();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_divider_tracker.md
Name: freq_divider_tracker

Overview:
- Counterpart to the frequency multiplier: measures the period of InFreq in RefClk cycles, then synthesises OutFreq with period = measured period × 2^n, i.e. InFreq divided by 2^n.
- Sits beside the multiplier on the same RefClk domain and uses the same adjust/done handshake style.
- Also reports the measured period and the lock time.

Parameters:
- WIDTH, 16, width of the period counter/register in RefClk cycles.

Ports:
- RefClk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- adjust  input  1  one-cycle request to (re)measure and relock; sampled every cycle.
- InFreq  input  1  asynchronous input square wave.
- n  input  3  divide exponent, 0..7; sampled when adjust is accepted.
- OutFreq  output  1  divided output clock.
- done  output  1  high while locked (state RUN).
- err  output  1  measurement failed; sticky until next accepted adjust or rst.
- period  output  WIDTH  last measured InFreq period in RefClk cycles.
- shiftduration  output  16  RefClk cycles from adjust acceptance to done rising; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=1 on a clock edge): state IDLE; OutFreq=0, done=0, err=0, period=0, shiftduration=0; all counters and synchronisers cleared. Reset wins over every other input and aborts any state.
- Input conditioning: InFreq passes through a 2-FF synchroniser, then a rising-edge detector. edge is high for one cycle, 3 cycles after a RefClk-aligned rise.
- adjust acceptance: adjust is accepted in IDLE, RUN, or after err.
  - On acceptance: latch n into n_r, clear err, done, OutFreq, and the lock timer, then go to WAIT1.
  - adjust is ignored in WAIT1, MEASURE, and SCALE.
- FSM:
  - IDLE: outputs hold.
  - WAIT1: wait for the first edge. On edge, cnt=1 and go to MEASURE.
  - MEASURE: cnt increments each cycle. On edge, period<=cnt, tgt<=cnt zero-extended to WIDTH+7 bits, shc=n_r, then go to SCALE, or to RUN if n_r=0.
  - SCALE: each cycle tgt<=tgt<<1 and shc--. Leave for RUN on the cycle shc reaches 0, so SCALE lasts exactly n_r cycles.
  - RUN: done=1. ocnt runs 0..tgt-1 and wraps. OutFreq=1 when ocnt < tgt>>1, else 0. An odd tgt gives low one cycle longer than high. ocnt=0 and OutFreq=1 on the first RUN cycle.
- Overflow and error:
  - If cnt reaches 2^WIDTH-1 in WAIT1 or MEASURE without an edge: err=1, go to IDLE, period unchanged.
  - A measured cnt<2 is impossible given the edge detector; no check is required.
- Lock timer: counts every cycle from the cycle after acceptance until the RUN entry cycle, inclusive. It is copied to shiftduration when done rises, saturating at 16'hFFFF.
- Period definition: number of RefClk cycles between consecutive edge pulses. A stable InFreq with period P (P≥2 RefClk cycles) gives period=P.
- Arithmetic: tgt is WIDTH+7 bits wide, so the shift never overflows.
- InFreq changing frequency during RUN has no effect until the next adjust.

Test Plan:
- RefClk-aligned InFreq period 10 (5 high/5 low), n=2, one adjust pulse -> period=10; 2 SCALE cycles; done rises; OutFreq 20 high/20 low repeating; shiftduration = measured cycles from adjust to done.
- Same InFreq, n=0 -> no SCALE cycles; OutFreq 5 high/5 low; done rises one cycle after the second edge is detected.
- InFreq period 7, n=1 -> tgt=14, OutFreq 7 high/7 low; with n=0 instead -> 3 high/4 low.
- WIDTH=8, InFreq held low, adjust -> err=1 exactly 255 cycles after entering WAIT1; state IDLE, done=0; a new adjust clears err.
- rst asserted mid-MEASURE -> next cycle all outputs 0 and state IDLE; with no adjust applied, no further activity despite edges.
- In RUN with n=2, adjust with n=3 -> done and OutFreq drop the next cycle; relock with OutFreq period 80; adjust pulses during MEASURE are ignored.
